// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor (2-bit counters indexed by GHR ^ PC) paired with a direct-mapped BTB.
// Prediction is combinational from fetch_pc; updates from EX and GHR recovery apply on the clock edge.
module gshare_btb_predictor #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned BTB_IDX_BITS = 5,
    parameter int unsigned HIST_BITS    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  fetch_pc,
    input  logic                 fetch_valid,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  next_pc,
    output logic [HIST_BITS-1:0] pred_pht_index,
    output logic [HIST_BITS-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_is_cond,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic [HIST_BITS-1:0] upd_pht_index,
    input  logic [HIST_BITS-1:0] upd_ghr,
    input  logic                 upd_mispredict
);
    localparam int unsigned TagW     = PC_WIDTH - BTB_IDX_BITS - 2;
    localparam int unsigned BtbDepth = 2 ** BTB_IDX_BITS;
    localparam int unsigned PhtDepth = 2 ** HIST_BITS;

    logic [BtbDepth-1:0] btb_valid_q;
    logic [BtbDepth-1:0] btb_cond_q;
    logic [TagW-1:0]     btb_tag_q [BtbDepth];
    logic [PC_WIDTH-1:0] btb_tgt_q [BtbDepth];
    logic [1:0]          pht_q     [PhtDepth];
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    logic [BTB_IDX_BITS-1:0] fetch_idx, upd_idx;
    logic [TagW-1:0]         fetch_tag, upd_tag;
    logic [HIST_BITS-1:0]    fetch_pht_idx;
    logic                    fetch_hit;
    logic                    btb_we, pht_we;
    logic [1:0]              pht_old, pht_new;

    // Word-alignment bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    always_comb begin
        fetch_idx      = fetch_pc[BTB_IDX_BITS+1:2];
        fetch_tag      = fetch_pc[PC_WIDTH-1:BTB_IDX_BITS+2];
        fetch_pht_idx  = ghr_q ^ fetch_pc[HIST_BITS+1:2];
        fetch_hit      = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
        pred_taken     = fetch_hit && (!btb_cond_q[fetch_idx] || pht_q[fetch_pht_idx][1]);
        next_pc        = pred_taken ? btb_tgt_q[fetch_idx] : fetch_pc + PC_WIDTH'(4);
        pred_pht_index = fetch_pht_idx;
        pred_ghr       = ghr_q;
    end

    always_comb begin
        upd_idx = upd_pc[BTB_IDX_BITS+1:2];
        upd_tag = upd_pc[PC_WIDTH-1:BTB_IDX_BITS+2];
        btb_we  = upd_valid && upd_taken;
        pht_we  = upd_valid && upd_is_cond;
        pht_old = pht_q[upd_pht_index];
        pht_new = pht_old;
        if (upd_taken && (pht_old != 2'b11)) begin
            pht_new = pht_old + 2'b01;
        end else if (!upd_taken && (pht_old != 2'b00)) begin
            pht_new = pht_old - 2'b01;
        end
    end

    // Recovery from a mispredict overrides any speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (fetch_valid && fetch_hit && btb_cond_q[fetch_idx]) begin
            ghr_d = {ghr_q[HIST_BITS-2:0], pred_taken};
        end
        if (upd_valid && upd_mispredict) begin
            ghr_d = upd_is_cond ? {upd_ghr[HIST_BITS-2:0], upd_taken} : upd_ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q       <= '0;
            btb_valid_q <= '0;
            for (int unsigned i = 0; i < PhtDepth; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            ghr_q <= ghr_d;
            if (btb_we) begin
                btb_valid_q[upd_idx] <= 1'b1;
            end
            if (pht_we) begin
                pht_q[upd_pht_index] <= pht_new;
            end
        end
    end

    // Tag, target and type are meaningless while the valid bit is clear, so they skip reset.
    always_ff @(posedge clk) begin
        if (!reset && btb_we) begin
            btb_tag_q[upd_idx]  <= upd_tag;
            btb_tgt_q[upd_idx]  <= upd_target;
            btb_cond_q[upd_idx] <= upd_is_cond;
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed-vector bench for gshare_btb_predictor: cold start, learning, saturation, aliasing,
// GHR recovery priority and reset overriding a live update.
module tb_gshare_btb_predictor;
    localparam int unsigned PW = 32;
    localparam int unsigned HB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] fetch_pc;
    logic          fetch_valid;
    logic          pred_taken;
    logic [PW-1:0] next_pc;
    logic [HB-1:0] pred_pht_index;
    logic [HB-1:0] pred_ghr;
    logic          upd_valid;
    logic [PW-1:0] upd_pc;
    logic          upd_is_cond;
    logic          upd_taken;
    logic [PW-1:0] upd_target;
    logic [HB-1:0] upd_pht_index;
    logic [HB-1:0] upd_ghr;
    logic          upd_mispredict;

    int checks   = 0;
    int failures = 0;

    gshare_btb_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .pred_taken     (pred_taken),
        .next_pc        (next_pc),
        .pred_pht_index (pred_pht_index),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_cond    (upd_is_cond),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pht_index  (upd_pht_index),
        .upd_ghr        (upd_ghr),
        .upd_mispredict (upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_upd();
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_is_cond    = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_pht_index  = '0;
        upd_ghr        = '0;
        upd_mispredict = 1'b0;
    endtask

    task automatic drive_upd(input logic [PW-1:0] pc, input logic cond, input logic taken,
                             input logic [PW-1:0] tgt, input logic [HB-1:0] pidx,
                             input logic [HB-1:0] ghr, input logic misp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_cond    = cond;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_pht_index  = pidx;
        upd_ghr        = ghr;
        upd_mispredict = misp;
    endtask

    task automatic update(input logic [PW-1:0] pc, input logic cond, input logic taken,
                          input logic [PW-1:0] tgt, input logic [HB-1:0] pidx,
                          input logic [HB-1:0] ghr, input logic misp);
        drive_upd(pc, cond, taken, tgt, pidx, ghr, misp);
        tick();
        clear_upd();
    endtask

    task automatic check_fetch(input string tag, input logic [PW-1:0] pc, input logic exp_taken,
                               input logic [PW-1:0] exp_next);
        fetch_pc = pc;
        settle();
        check_eq({tag, "_taken"}, 64'(pred_taken), 64'(exp_taken));
        check_eq({tag, "_next"}, 64'(next_pc), 64'(exp_next));
    endtask

    task automatic check_pht_all_weak(input string tag);
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (dut.pht_q[i] !== 2'b01) bad++;
        end
        check_eq(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        fetch_pc    = '0;
        fetch_valid = 1'b0;
        clear_upd();
        tick();
        tick();
        reset = 1'b0;

        // Cold start
        fetch_valid = 1'b1;
        check_fetch("cold", 32'h100, 1'b0, 32'h104);
        check_eq("cold_ghr", 64'(pred_ghr), 64'h0);
        check_eq("cold_pidx", 64'(pred_pht_index), 64'h0);
        check_pht_all_weak("cold_pht");

        // JAL learn; same-cycle fetch still sees the old (empty) entry
        drive_upd(32'h100, 1'b0, 1'b1, 32'h200, 5'd0, 5'd0, 1'b1);
        fetch_pc = 32'h100;
        settle();
        check_eq("rdw_taken", 64'(pred_taken), 64'h0);
        tick();
        clear_upd();
        check_fetch("jal", 32'h100, 1'b1, 32'h200);
        tick();
        check_eq("jal_ghr", 64'(pred_ghr), 64'h0);

        // Counter saturation on branch 0x40 with fixed PHT index 16
        fetch_valid = 1'b0;
        for (int i = 0; i < 4; i++) update(32'h40, 1'b1, 1'b1, 32'h80, 5'd16, 5'd0, 1'b0);
        check_eq("sat_ctr3", 64'(dut.pht_q[16]), 64'd3);
        check_fetch("sat_t", 32'h40, 1'b1, 32'h80);
        check_eq("sat_pidx", 64'(pred_pht_index), 64'd16);
        check_fetch("alias", 32'h840, 1'b0, 32'h844);
        update(32'h40, 1'b1, 1'b0, 32'h80, 5'd16, 5'd0, 1'b0);
        check_eq("sat_ctr2", 64'(dut.pht_q[16]), 64'd2);
        check_fetch("sat_wt", 32'h40, 1'b1, 32'h80);
        update(32'h40, 1'b1, 1'b0, 32'h80, 5'd16, 5'd0, 1'b0);
        update(32'h40, 1'b1, 1'b0, 32'h80, 5'd16, 5'd0, 1'b0);
        check_eq("sat_ctr0", 64'(dut.pht_q[16]), 64'd0);
        check_fetch("sat_nt", 32'h40, 1'b0, 32'h44);
        update(32'h40, 1'b1, 1'b0, 32'h80, 5'd16, 5'd0, 1'b0);
        check_eq("sat_floor", 64'(dut.pht_q[16]), 64'd0);

        // Recovery priority: ghr=10110, fetch 0x40 -> pidx 10110^10000=6
        update(32'h40, 1'b1, 1'b1, 32'h80, 5'd6, 5'd0, 1'b0);
        update(32'h304, 1'b0, 1'b1, 32'h400, 5'd0, 5'b10110, 1'b1);
        settle();
        check_eq("jalr_rec_ghr", 64'(pred_ghr), 64'h16);
        fetch_valid = 1'b1;
        check_fetch("prio_fetch", 32'h40, 1'b1, 32'h80);
        check_eq("prio_pidx", 64'(pred_pht_index), 64'd6);
        drive_upd(32'h500, 1'b1, 1'b0, 32'h600, 5'd9, 5'b00011, 1'b1);
        tick();
        clear_upd();
        settle();
        check_eq("prio_ghr", 64'(pred_ghr), 64'h06);

        // Speculative shift: ghr=00110, pidx 22 (weak NT) -> shift in 0
        check_fetch("spec_fetch", 32'h40, 1'b0, 32'h44);
        tick();
        settle();
        check_eq("spec_ghr", 64'(pred_ghr), 64'h0C);
        fetch_valid = 1'b0;
        tick();
        settle();
        check_eq("hold_ghr", 64'(pred_ghr), 64'h0C);

        // Reset mid-operation with a live update in the reset cycle
        check_fetch("pre_rst", 32'h100, 1'b1, 32'h200);
        reset = 1'b1;
        drive_upd(32'h40, 1'b1, 1'b1, 32'h80, 5'd6, 5'h1F, 1'b1);
        tick();
        reset = 1'b0;
        clear_upd();
        check_fetch("rst_jal", 32'h100, 1'b0, 32'h104);
        check_fetch("rst_br", 32'h40, 1'b0, 32'h44);
        check_eq("rst_ghr", 64'(pred_ghr), 64'h0);
        check_pht_all_weak("rst_pht");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
